// File: rtl/fphub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fphub_pkg
// Description : Shared types and helpers for the HUB floating-point units:
//               format defaults, exponent bias, special-operand detection,
//               divider FSM states and operand classes.
// Revision    : 1.0 - initial release
// ============================================================================
package fphub_pkg;

  localparam int M_DEF = 23;
  localparam int E_DEF = 8;

  // Exponent bias of the HUB format is 2^(E-1).
  function automatic int bias_of(input int e_w);
    return 1 << (e_w - 1);
  endfunction

  localparam int BIAS = bias_of(E_DEF);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  // Result class decided when the operation is accepted.
  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF} cls_t;

  // Zero encoding: exponent field all zeros.
  function automatic logic exp_is_zero(input logic [31:0] ex);
    return ex == 32'd0;
  endfunction

  // Infinity encoding: exponent field all ones.
  function automatic logic exp_is_inf(input logic [31:0] ex, input int e_w);
    return ex == ((32'd1 << e_w) - 32'd1);
  endfunction

  // Special-operand priority for division: 0/x, x/0, inf/x, x/inf.
  function automatic cls_t div_classify(input logic [31:0] xe,
                                        input logic [31:0] ye,
                                        input int e_w);
    if (exp_is_zero(xe))           return CLS_ZERO;
    else if (exp_is_zero(ye))      return CLS_INF;
    else if (exp_is_inf(xe, e_w))  return CLS_INF;
    else if (exp_is_inf(ye, e_w))  return CLS_ZERO;
    else                           return CLS_NORM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fphub_div_core.sv
`default_nettype none
// ============================================================================
// Module      : fphub_div_core
// Description : Restoring radix-2 significand divider, one quotient bit per
//               step. load initialises the remainder and iteration counter;
//               done is high once the counter has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fphub_div_core #(
  parameter int M = 23
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load,
  input  logic         step,
  input  logic [M+2:0] dividend,
  input  logic [M+1:0] divisor,
  output logic [M-1:0] mant,
  output logic         done
);

  localparam int CW = $clog2(M + 1);

  logic [M+2:0] rem;
  logic [M+2:0] rem_nx;
  logic [M+2:0] dsr_ext;
  logic [M+1:0] dsr;
  logic [M-1:0] q;
  logic [CW-1:0] cnt;
  logic          ge;

  // Trial subtraction; the remainder is restored when it would go negative.
  always_comb begin
    dsr_ext = {1'b0, dsr};
    ge      = (rem >= dsr_ext);
    rem_nx  = ge ? (rem - dsr_ext) : rem;
  end

  // Remainder, divisor, quotient shift register and iteration counter.
  // The leading quotient 1 shifts out of q, leaving only the fraction bits.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rem <= '0;
      dsr <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= dividend;
      dsr <= divisor;
      q   <= '0;
      cnt <= CW'(M);
    end else if (step) begin
      rem <= rem_nx << 1;
      q   <= {q[M-2:0], ge};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign mant = q;
  assign done = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fphub_div.sv
`default_nettype none
// ============================================================================
// Module      : fphub_div
// Description : Iterative HUB floating-point divider Z = X / Y. Handles sign,
//               special operands, exponent over/underflow and significand
//               pre-normalisation; the mantissa comes from fphub_div_core.
// Revision    : 1.0 - initial release
// ============================================================================
module fphub_div
  import fphub_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int E = E_DEF
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         start,
  input  logic [E+M:0] X,
  input  logic [E+M:0] Y,
  output logic [E+M:0] Z,
  output logic         finish,
  output logic         busy
);

  localparam int EW = E + 2;
  localparam logic signed [E+1:0] EXP_BIAS = EW'(bias_of(E));
  localparam logic signed [E+1:0] EXP_OVF  = EW'((1 << E) - 1);

  state_t state, state_nx;
  cls_t   op_cls, acc_cls, cls_r;

  logic [M+1:0]        sx, sy;
  logic [M+2:0]        dividend;
  logic                adj;
  logic signed [E+1:0] exp_calc;
  logic                sign_r;
  logic [E-1:0]        exp_r;
  logic                load, step, core_done;
  logic [M-1:0]        core_mant;

  // Operand decode: significands with both implicit ones, pre-normalisation,
  // biased exponent difference and final result class.
  always_comb begin
    sx       = {1'b1, X[M-1:0], 1'b1};
    sy       = {1'b1, Y[M-1:0], 1'b1};
    adj      = (sx < sy);
    dividend = adj ? {sx, 1'b0} : {1'b0, sx};
    exp_calc = $signed({2'b00, X[E+M-1:M]}) - $signed({2'b00, Y[E+M-1:M]})
             + EXP_BIAS - $signed({{(E+1){1'b0}}, adj});
    op_cls   = div_classify(32'(X[E+M-1:M]), 32'(Y[E+M-1:M]), E);
    if (op_cls != CLS_NORM)            acc_cls = op_cls;
    else if (exp_calc >= EXP_OVF)      acc_cls = CLS_INF;
    else if (exp_calc <= $signed({EW{1'b0}})) acc_cls = CLS_ZERO;
    else                               acc_cls = CLS_NORM;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and core control.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (acc_cls == CLS_NORM) ? DIV : DONE;
        end
      end
      DIV: begin
        step = 1'b1;
        if (core_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch at accept, result write in DONE, handshake outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sign_r <= 1'b0;
      exp_r  <= '0;
      cls_r  <= CLS_NORM;
      Z      <= '0;
      finish <= 1'b0;
      busy   <= 1'b0;
    end else begin
      finish <= (state == DONE);
      busy   <= (state != IDLE) || start;
      if (state == IDLE && start) begin
        sign_r <= X[E+M] ^ Y[E+M];
        exp_r  <= exp_calc[E-1:0];
        cls_r  <= acc_cls;
      end
      if (state == DONE) begin
        unique case (cls_r)
          CLS_ZERO: Z <= {sign_r, {E{1'b0}}, {M{1'b0}}};
          CLS_INF:  Z <= {sign_r, {E{1'b1}}, {M{1'b0}}};
          default:  Z <= {sign_r, exp_r, core_mant};
        endcase
      end
    end
  end

  fphub_div_core #(.M(M)) u_core (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (load),
    .step     (step),
    .dividend (dividend),
    .divisor  (sy),
    .mant     (core_mant),
    .done     (core_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_fphub_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_fphub_div
// Description : Directed self-checking bench for fphub_div (M=23, E=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fphub_div;

  logic        clk;
  logic        rst_l;
  logic        start;
  logic [31:0] x, y;
  logic [31:0] z;
  logic        finish, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int nfin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fphub_div #(.M(23), .E(8)) dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .start  (start),
    .X      (x),
    .Y      (y),
    .Z      (z),
    .finish (finish),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for finish, sampling 1 time unit after each rising edge.
  task automatic wait_finish();
    lat = 0;
    while (finish !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One operation: accept, scramble operands, check result, latency, pulse.
  task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                        input logic [31:0] ez, input int elat);
    @(negedge clk);
    x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = $urandom;
    wait_finish();
    chk({tag, "_z"}, z, ez);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_fin_lo"}, {31'd0, finish}, 32'd0);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_l = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", z, 32'h0);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_l = 1'b1;

    run_op("one_div_one", 32'h40000000, 32'h40000000, 32'h40000000, 25);
    run_op("two_div_one", 32'h40800000, 32'h40000000, 32'h40800000, 25);
    run_op("neg_sign",    32'hC0000000, 32'h40000000, 32'hC0000000, 25);
    run_op("prenorm",     32'h40000000, 32'h40400000, 32'h3FAAAAAA, 25);
    run_op("hub_trunc",   32'h40400000, 32'h40000000, 32'h403FFFFF, 25);
    run_op("x_zero",      32'h00000000, 32'h40000000, 32'h00000000, 1);
    run_op("y_zero",      32'h40000000, 32'h00000000, 32'h7F800000, 1);
    run_op("ovf",         32'h7F000000, 32'h00800000, 32'h7F800000, 1);
    run_op("x_inf_neg",   32'h7F800000, 32'hC0000000, 32'hFF800000, 1);
    run_op("unf",         32'h00800000, 32'h7F000000, 32'h00000000, 1);
    run_op("y_inf_neg",   32'hC0000000, 32'h7F800000, 32'h80000000, 1);

    // start held high through the division with different operands on X/Y.
    @(negedge clk);
    x = 32'h40800000; y = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    x = 32'h7F800000; y = 32'h00000000;
    wait_finish();
    start = 1'b0;
    chk("hold_z", z, 32'h40800000);
    chk("hold_lat", 32'(lat), 32'd25);
    nfin = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finish) nfin++;
    end
    chk("hold_extra_fin", 32'(nfin), 32'd0);

    // Reset in the middle of a division.
    @(negedge clk);
    x = 32'h40000000; y = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_z", z, 32'h0);
    chk("mid_rst_finish", {31'd0, finish}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_l = 1'b1;
    nfin = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (finish) nfin++;
    end
    chk("post_rst_no_fin", 32'(nfin), 32'd0);
    run_op("after_rst", 32'hC0000000, 32'h40000000, 32'hC0000000, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
